risc_v_lsu_bus_master: RTL and testbench
========================================

Name: risc_v_lsu_bus_master

Overview:
- Load/store initiator on the CPU side of the memory bus. It drives the rd/wr address, read/write strobes and write data that the memory controller responds to.
- Accepts one load or store from the execute stage and sequences the bus transaction.
- Performs read-modify-write for SB/SH, because the bus has no byte enables.
- Returns sign/zero-extended load data to writeback and raises a stall while busy.

Parameters:
- DATA_W, 32, data and address width (matches DATA_32_W).
- TIMEOUT_CYCLES, 16, cycles waiting for mem_bus_ack before abort (used only with the optional feature).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  execute stage presents a memory op
- req_ready  output  1  LSU can accept a request (FSM in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  DATA_W  byte address
- req_wdata  input  DATA_W  store data (low bytes used for B/H)
- resp_valid  output  1  one-cycle pulse: op complete
- resp_rdata  output  DATA_W  extended load data (0 for stores)
- resp_err  output  1  valid with resp_valid: misaligned, illegal funct3, or timeout
- lsu_stall  output  1  = accepted op in flight (state != IDLE)
- mem_bus_rd_addr  output  DATA_W  word-aligned read address
- mem_bus_wr_addr  output  DATA_W  word-aligned write address
- mem_bus_read  output  1  read strobe, held until ack
- mem_bus_write  output  1  write strobe, held until ack
- mem_bus_wr_data  output  DATA_W  full-word write data
- mem_bus_rd_data  input  DATA_W  read data, valid when mem_bus_ack
- mem_bus_ack  input  1  responder completes current strobe (1 cycle)

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state IDLE; internal registers 0.
- States: IDLE, RD, WR, RESP.
- Accept rule: request captured on the clk edge with req_valid & req_ready. Addr, funct3, wdata and write are registered.
- Word address: waddr = {addr[31:2],2'b00}.
- Transitions from IDLE after capture:
  - LW/LB/LBU/LH/LHU → RD.
  - SW → WR.
  - SB/SH → RD (RMW read phase).
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) → RESP with err; no bus strobe.
  - Illegal funct3 (011, 110, 111; stores also 100, 101) → RESP with err; no bus strobe.
- RD: mem_bus_read=1, mem_bus_rd_addr=waddr. On ack, latch rd_data.
  - Load → RESP.
  - SB/SH → WR.
- WR: mem_bus_write=1, mem_bus_wr_addr=waddr.
  - mem_bus_wr_data = wdata for SW.
  - For SB/SH: latched word with byte lane addr[1:0] (B) or half lane addr[1] (H) replaced by wdata[7:0]/[15:0].
  - On ack → RESP.
- RESP: resp_valid=1 for exactly one cycle → IDLE. resp_rdata is registered:
  - B/BU: lane byte sign/zero-extended.
  - H/HU: lane half extended.
  - W: whole word.
- Strobes: read and write never both high. Addresses and wr_data are stable while a strobe is high. A strobe deasserts the cycle after ack.
- Ack outside RD/WR is ignored.
- Latency:
  - Load: 1 + bus wait + 1 cycles accept→resp_valid; minimum 3 with ack in first RD cycle.
  - SW: min 3.
  - SB/SH: min 4.
- No new request is accepted until back in IDLE. req_valid during RESP is accepted the next cycle.
- Async reset mid-transaction: immediately drop strobes and resp_valid, return to IDLE, lose the op.

Optional Feature:
- RISC_V_LSU_TIMEOUT_EN defined:
  - Counter resets on entry to RD/WR and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES, drop the strobe → RESP with resp_err=1, resp_rdata=0.
  - Covers unmapped regions with no responder.
- Not defined: no counter; LSU waits indefinitely for ack.

Test Plan:
- LW addr 0x10010000, responder ack after 2 cycles with rd_data 0xDEADBEEF → mem_bus_rd_addr 0x10010000, resp_rdata 0xDEADBEEF, err 0, resp_valid 4 cycles after accept.
- LB addr 0x10010003, mem word 0x80112233 → rd_addr 0x10010000, resp_rdata 0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x10010002 → 0x00008011.
- SB addr 0x7fffeffd wdata 0x000000AA, mem word 0x11223344 → read then write to 0x7fffeffc with wr_data 0x1122AA44, read/write never overlap.
- LW addr 0x00400002 and SH addr 0x10010001 → resp_err 1 two cycles after accept, mem_bus_read/write stay 0.
- rst_n low while mem_bus_write held (SW 0xffff0000) → strobe 0 same instant, req_ready 1, no resp_valid after release.
- With RISC_V_LSU_TIMEOUT_EN, LW to 0x10f10000 with no ack → read dropped after 16 cycles, resp_valid with resp_err 1.

Source files
------------

// File: rtl/risc_v_lsu_bus_master.sv
// Load/store bus master: one op at a time, RMW for SB/SH, sign/zero-extended loads.
// Optional bus timeout is enabled by defining RISC_V_LSU_TIMEOUT_EN.
module risc_v_lsu_bus_master #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              lsu_stall,
  output logic [DATA_W-1:0] mem_bus_rd_addr,
  output logic [DATA_W-1:0] mem_bus_wr_addr,
  output logic              mem_bus_read,
  output logic              mem_bus_write,
  output logic [DATA_W-1:0] mem_bus_wr_data,
  input  logic [DATA_W-1:0] mem_bus_rd_data,
  input  logic              mem_bus_ack
);

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high; req_ready is high only in IDLE. Bus strobes are held until the
  // edge that samples mem_bus_ack and drop in the following cycle.
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              f3_ok;
  logic              misal;
  logic              req_err;
  logic [DATA_W-1:0] req_waddr;
  logic [DATA_W-1:0] cur_waddr;
  logic              tmo_hit;

  always_comb begin
    f3_ok = 1'b0;
    misal = 1'b0;
    case (req_funct3)
      3'b000: f3_ok = 1'b1;
      3'b001: begin f3_ok = 1'b1; misal = req_addr[0]; end
      3'b010: begin f3_ok = 1'b1; misal = |req_addr[1:0]; end
      3'b100: f3_ok = !req_write;
      3'b101: begin f3_ok = !req_write; misal = req_addr[0]; end
      default: f3_ok = 1'b0;
    endcase
  end

  assign req_err   = !f3_ok || misal;
  assign req_waddr = {req_addr[DATA_W-1:2], 2'b00};
  assign cur_waddr = {addr_q[DATA_W-1:2], 2'b00};
  assign lsu_stall = (state != IDLE);

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] w,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_ext = {{(DATA_W-8){b[7]}}, b};
      3'b100:  load_ext = {{(DATA_W-8){1'b0}}, b};
      3'b001:  load_ext = {{(DATA_W-16){h[15]}}, h};
      3'b101:  load_ext = {{(DATA_W-16){1'b0}}, h};
      default: load_ext = w;
    endcase
  endfunction

  // Splice store data into the word fetched by the RMW read phase.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w,
                                              input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [DATA_W-1:0] wd);
    merge = w;
    if (f3[1:0] == 2'b00) merge[{off, 3'b000} +: 8] = wd[7:0];
    else                  merge[{off[1], 4'b0000} +: 16] = wd[15:0];
  endfunction

`ifdef RISC_V_LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == RD || state == WR) && !mem_bus_ack &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if ((state == RD || state == WR) && !mem_bus_ack && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      write_q         <= 1'b0;
      funct3_q        <= 3'b000;
      addr_q          <= '0;
      wdata_q         <= '0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      mem_bus_rd_addr <= '0;
      mem_bus_wr_addr <= '0;
      mem_bus_read    <= 1'b0;
      mem_bus_write   <= 1'b0;
      mem_bus_wr_data <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && req_funct3 == 3'b010) begin
              state           <= WR;
              mem_bus_write   <= 1'b1;
              mem_bus_wr_addr <= req_waddr;
              mem_bus_wr_data <= req_wdata;
            end else begin
              state           <= RD;
              mem_bus_read    <= 1'b1;
              mem_bus_rd_addr <= req_waddr;
            end
          end
        end
        RD: begin
          if (mem_bus_ack) begin
            mem_bus_read <= 1'b0;
            if (write_q) begin
              state           <= WR;
              mem_bus_write   <= 1'b1;
              mem_bus_wr_addr <= cur_waddr;
              mem_bus_wr_data <= merge(mem_bus_rd_data, funct3_q, addr_q[1:0], wdata_q);
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= load_ext(mem_bus_rd_data, funct3_q, addr_q[1:0]);
            end
          end else if (tmo_hit) begin
            mem_bus_read <= 1'b0;
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b1;
            resp_rdata   <= '0;
          end
        end
        WR: begin
          if (mem_bus_ack || tmo_hit) begin
            mem_bus_write <= 1'b0;
            state         <= RESP;
            resp_valid    <= 1'b1;
            resp_err      <= !mem_bus_ack;
            resp_rdata    <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          resp_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_v_lsu_bus_master.sv
// Directed + randomized bench for risc_v_lsu_bus_master with a word-level memory model.
// Define RISC_V_LSU_TIMEOUT_EN for both files to exercise the bus timeout.
module tb_risc_v_lsu_bus_master;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [DATA_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              lsu_stall;
  logic [DATA_W-1:0] mem_bus_rd_addr;
  logic [DATA_W-1:0] mem_bus_wr_addr;
  logic              mem_bus_read;
  logic              mem_bus_write;
  logic [DATA_W-1:0] mem_bus_wr_data;
  logic [DATA_W-1:0] mem_bus_rd_data = '0;
  logic              mem_bus_ack = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int last_rd_cycles;

  logic [31:0] mem [logic [31:0]];

  risc_v_lsu_bus_master #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .lsu_stall(lsu_stall),
    .mem_bus_rd_addr(mem_bus_rd_addr), .mem_bus_wr_addr(mem_bus_wr_addr),
    .mem_bus_read(mem_bus_read), .mem_bus_write(mem_bus_write),
    .mem_bus_wr_data(mem_bus_wr_data), .mem_bus_rd_data(mem_bus_rd_data),
    .mem_bus_ack(mem_bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op; the responder acks in strobe cycle 'dly' (dly == 0: never acks).
  task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int dly);
    logic [31:0] waddr, word, val, mask, exp_rd, exp_wr;
    logic [31:0] rec_rd_addr, rec_wr_addr, rec_wr_data, got_rd, got_wr_addr, got_wr_data;
    logic        legal, exp_err, exp_read, exp_write, got_err;
    logic        got_resp, read_seen, write_seen, overlap, unstable, stall_bad;
    logic [1:0]  cur, prev;
    int          size, sh, exp_lat, idx, scnt;

    waddr = addr & 32'hFFFF_FFFC;
    if (!mem.exists(waddr)) mem[waddr] = $urandom;
    word = mem[waddr];

    legal = wr ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    sh    = 8 * int'(addr % 4);
    exp_err = !legal || (addr % size != 0);
    exp_rd = 0; exp_wr = 0; exp_read = 0; exp_write = 0; exp_lat = 2;
    if (!exp_err && !wr) begin
      exp_read = 1;
      exp_lat  = 2 + dly;
      val = word >> sh;
      if (size == 1) begin
        val = val & 32'hFF;
        if (f3 == 3'd0 && val >= 128) val = val - 256;
      end else if (size == 2) begin
        val = val & 32'hFFFF;
        if (f3 == 3'd1 && val >= 32768) val = val - 65536;
      end
      exp_rd = val;
    end else if (!exp_err) begin
      exp_write = 1;
      exp_read  = (size < 4);
      mask   = (size == 1) ? 32'hFF : 32'hFFFF;
      exp_wr = (size == 4) ? wd : ((word & ~(mask << sh)) | ((wd & mask) << sh));
      exp_lat = 2 + dly + (exp_read ? dly : 0);
      mem[waddr] = exp_wr;
    end
    if (dly == 0 && !exp_err) begin
      exp_err = 1; exp_rd = 0; exp_write = 0; exp_lat = 2 + TMO;
    end

    @(posedge clk); #1;
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    idx = 0; scnt = 0; prev = 2'b00; got_resp = 0;
    read_seen = 0; write_seen = 0; overlap = 0; unstable = 0; stall_bad = 0;
    rec_rd_addr = 0; rec_wr_addr = 0; rec_wr_data = 0; got_wr_addr = 0; got_wr_data = 0;
    got_rd = 0; got_err = 0; last_rd_cycles = 0;
    forever begin
      mem_bus_ack = 1'b0;
      cur = {mem_bus_read, mem_bus_write};
      if (mem_bus_read && mem_bus_write) overlap = 1;
      if (lsu_stall !== 1'b1) stall_bad = 1;
      if (cur != 2'b00) begin
        if (cur != prev) begin
          scnt = 0;
          rec_rd_addr = mem_bus_rd_addr; rec_wr_addr = mem_bus_wr_addr;
          rec_wr_data = mem_bus_wr_data;
        end else if (mem_bus_read && rec_rd_addr !== mem_bus_rd_addr) begin
          unstable = 1;
        end else if (mem_bus_write && (rec_wr_addr !== mem_bus_wr_addr ||
                                       rec_wr_data !== mem_bus_wr_data)) begin
          unstable = 1;
        end
        scnt++;
        if (mem_bus_read) begin
          read_seen = 1; last_rd_cycles++;
        end
        if (mem_bus_write) begin
          write_seen = 1; got_wr_addr = mem_bus_wr_addr; got_wr_data = mem_bus_wr_data;
        end
        if (dly != 0 && scnt == dly) begin
          mem_bus_ack = 1'b1;
          mem_bus_rd_data = mem_bus_read ? word : $urandom;
        end
      end
      prev = cur;
      if (resp_valid === 1'b1) begin
        got_resp = 1; got_rd = resp_rdata; got_err = resp_err;
        break;
      end
      if (idx >= 200) break;
      @(posedge clk); #1;
      idx++;
    end
    mem_bus_ack = 1'b0;

    check("resp_seen", {31'b0, got_resp}, 32'd1);
    check("resp_err", {31'b0, got_err}, {31'b0, exp_err});
    check("resp_rdata", got_rd, exp_rd);
    check("latency", idx + 2, exp_lat);
    check("read_strobe_seen", {31'b0, read_seen}, {31'b0, exp_read});
    check("write_strobe_seen", {31'b0, write_seen}, {31'b0, exp_write});
    check("no_overlap", {31'b0, overlap}, 32'd0);
    check("strobe_stable", {31'b0, unstable}, 32'd0);
    check("stall_in_flight", {31'b0, stall_bad}, 32'd0);
    if (exp_read) check("rd_addr", rec_rd_addr, waddr);
    if (exp_write) begin
      check("wr_addr", got_wr_addr, waddr);
      check("wr_data", got_wr_data, exp_wr);
    end
    @(posedge clk); #1;
    check("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
    check("ready_after_resp", {31'b0, req_ready}, 32'd1);
    check("stall_after_resp", {31'b0, lsu_stall}, 32'd0);
  endtask

  initial begin : main
    logic saw_resp;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_stall", {31'b0, lsu_stall}, 32'd0);
    check("rst_strobes", {30'b0, mem_bus_read, mem_bus_write}, 32'd0);
    check("rst_rd_addr", mem_bus_rd_addr, 32'd0);
    check("rst_wr_addr", mem_bus_wr_addr, 32'd0);
    check("rst_wr_data", mem_bus_wr_data, 32'd0);
    rst_n = 1'b1;

    // directed cases
    mem[32'h1001_0000] = 32'hDEAD_BEEF;
    run_op(1'b0, 3'b010, 32'h1001_0000, 32'h0, 2);
    mem[32'h1001_0000] = 32'h8011_2233;
    run_op(1'b0, 3'b000, 32'h1001_0003, 32'h0, 1);
    run_op(1'b0, 3'b100, 32'h1001_0003, 32'h0, 1);
    run_op(1'b0, 3'b101, 32'h1001_0002, 32'h0, 3);
    run_op(1'b0, 3'b001, 32'h1001_0000, 32'h0, 1);
    mem[32'h7FFF_EFFC] = 32'h1122_3344;
    run_op(1'b1, 3'b000, 32'h7FFF_EFFD, 32'h0000_00AA, 1);
    run_op(1'b1, 3'b001, 32'h7FFF_EFFE, 32'h1234_5678, 2);
    run_op(1'b1, 3'b010, 32'h7FFF_EFFC, 32'hCAFE_F00D, 1);
    run_op(1'b0, 3'b010, 32'h0040_0002, 32'h0, 1);
    run_op(1'b1, 3'b001, 32'h1001_0001, 32'h0, 1);
    run_op(1'b0, 3'b011, 32'h1001_0000, 32'h0, 1);
    run_op(1'b1, 3'b100, 32'h1001_0000, 32'h0, 1);

    // stray ack while idle
    @(posedge clk); #1;
    mem_bus_ack = 1'b1;
    @(posedge clk); #1;
    mem_bus_ack = 1'b0;
    check("idle_ack_ready", {31'b0, req_ready}, 32'd1);
    check("idle_ack_resp", {31'b0, resp_valid}, 32'd0);
    check("idle_ack_strobes", {30'b0, mem_bus_read, mem_bus_write}, 32'd0);

    // randomized ops
    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'h1001_0000 + 32'($urandom_range(0, 31)), $urandom, $urandom_range(1, 4));
    end

    // async reset while a store strobe is held
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'hFFFF_0000; req_wdata = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_write_high", {31'b0, mem_bus_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_write_drop", {31'b0, mem_bus_write}, 32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_stall", {31'b0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid || mem_bus_write) saw_resp = 1'b1;
    end
    check("rst_mid_no_resp", {31'b0, saw_resp}, 32'd0);

`ifdef RISC_V_LSU_TIMEOUT_EN
    run_op(1'b0, 3'b010, 32'h10F1_0000, 32'h0, 0);
    check("timeout_read_cycles", last_rd_cycles, TMO);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
